// File: rtl/ifetch_buf_pkg.sv
// Shared constants, fetch FSM state type and vector predecode helper for ifetch_buf.
package ifetch_buf_pkg;

    localparam logic [6:0]  OPC_OPV     = 7'b1010111;
    localparam logic [6:0]  OPC_LOADFP  = 7'b0000111;
    localparam logic [6:0]  OPC_STOREFP = 7'b0100111;
    localparam logic [31:0] INST_TERM   = 32'h0000_0000;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } fetch_state_e;

    // Vector loads/stores share the FP opcodes; the width field separates them.
    function automatic logic is_vec_inst(input logic [31:0] inst);
        logic vec_width;
        vec_width = (inst[14:12] == 3'b000) || (inst[14:12] == 3'b101) ||
                    (inst[14:12] == 3'b110) || (inst[14:12] == 3'b111);
        return (inst[6:0] == OPC_OPV) ||
               (((inst[6:0] == OPC_LOADFP) || (inst[6:0] == OPC_STOREFP)) && vec_width);
    endfunction

endpackage

// File: rtl/ifetch_buf_fifo.sv
// Generic synchronous FIFO with flush; a push into a full FIFO is accepted when a pop occurs in the same cycle.
module ifetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    rd_ptr_r;
    logic [AW-1:0]    wr_ptr_r;
    logic [CW-1:0]    count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full      = (count_r == CW'(DEPTH));
    assign empty     = (count_r == CW'(0));
    assign pop_ok_s  = pop & ~empty;
    assign push_ok_s = push & (~full | pop_ok_s);
    assign rdata     = mem_r[rd_ptr_r];
    assign count     = count_r;

    // Storage array; contents need no reset since count gates validity.
    always_ff @(posedge clk) begin
        if (!rst && !flush && push_ok_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Pointers and occupancy; flush behaves like reset for bookkeeping.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr_r <= AW'(0);
            wr_ptr_r <= AW'(0);
            count_r  <= CW'(0);
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/ifetch_buf.sv
// Instruction fetch stage with prefetch queue; optional vector predecode flag under IFETCH_VPREDECODE_EN.
module ifetch_buf
    import ifetch_buf_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_a,
    input  logic [31:0] imem_inst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc,
    output logic        id_is_vec,
    output logic        halted
);

    localparam int CW = $clog2(DEPTH+1);
`ifdef IFETCH_VPREDECODE_EN
    localparam int EW = 65;
`else
    localparam int EW = 64;
`endif

    fetch_state_e  state_r;
    fetch_state_e  state_nxt;
    logic [31:0]   fpc_r;
    logic [31:0]   fpc_nxt;
    logic          push_s;
    logic          pop_s;
    logic          can_accept_s;
    logic          full_s;
    logic          empty_s;
    logic [CW-1:0] count_s;
    logic [EW-1:0] wdata_s;
    logic [EW-1:0] rdata_s;

    assign imem_a       = fpc_r;
    assign id_valid     = ~empty_s;
    assign pop_s        = id_valid & id_ready;
    assign can_accept_s = ~full_s | pop_s;
    assign halted       = (state_r == ST_HALT) && (count_s == CW'(0));

`ifdef IFETCH_VPREDECODE_EN
    assign wdata_s   = {is_vec_inst(imem_inst), fpc_r, imem_inst};
    assign id_is_vec = rdata_s[64];
`else
    assign wdata_s   = {fpc_r, imem_inst};
    assign id_is_vec = 1'b0;
`endif
    assign id_pc   = rdata_s[63:32];
    assign id_inst = rdata_s[31:0];

    // Fetch state and PC registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_RUN;
            fpc_r   <= RESET_PC;
        end else begin
            state_r <= state_nxt;
            fpc_r   <= fpc_nxt;
        end
    end

    // Next-state: redirect wins, then terminator detection, then sequential fetch.
    always_comb begin
        state_nxt = state_r;
        fpc_nxt   = fpc_r;
        push_s    = 1'b0;
        if (redirect_valid) begin
            state_nxt = ST_RUN;
            fpc_nxt   = redirect_pc & 32'hFFFF_FFFC;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (can_accept_s) begin
                        if (imem_inst == INST_TERM) begin
                            state_nxt = ST_HALT;
                        end else begin
                            push_s  = 1'b1;
                            fpc_nxt = fpc_r + 32'd4;
                        end
                    end else begin
                        state_nxt = ST_RUN;
                    end
                end
                ST_HALT: begin
                    state_nxt = ST_HALT;
                end
                default: begin
                    state_nxt = ST_RUN;
                end
            endcase
        end
    end

    ifetch_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (redirect_valid),
        .push  (push_s),
        .pop   (pop_s),
        .wdata (wdata_s),
        .rdata (rdata_s),
        .count (count_s),
        .full  (full_s),
        .empty (empty_s)
    );

endmodule

// File: tb/tb_ifetch_buf.sv
// Directed table-driven bench for ifetch_buf with a small ROM model and hand-written halt/redirect/vector sequences.
module tb_ifetch_buf;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_a;
    logic [31:0] imem_inst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic        id_is_vec;
    logic        halted;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Program image: terminator at 0xB4, vector test words at 0x100..0x108.
    function automatic logic [31:0] rom_word(input logic [6:0] idx);
        case (idx)
            7'd0:    return 32'hFFC1_0113;
            7'd45:   return 32'h0000_0000;
            7'd64:   return 32'h0205_6087;
            7'd65:   return 32'h0106_7457;
            7'd66:   return 32'h0040_0513;
            default: return 32'h0000_0013 | ({25'd0, idx} << 20);
        endcase
    endfunction

    assign imem_inst = rom_word(imem_a[8:2]);

    ifetch_buf dut (
        .clk            (clk),
        .rst            (rst),
        .imem_a         (imem_a),
        .imem_inst      (imem_inst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_inst        (id_inst),
        .id_pc          (id_pc),
        .id_is_vec      (id_is_vec),
        .halted         (halted)
    );

    typedef struct {
        logic        rst;
        logic        rv;
        logic [31:0] rpc;
        logic        rdy;
        logic        e_valid;
        logic        chk_pc;
        logic [31:0] e_pc;
        logic        chk_inst;
        logic [31:0] e_inst;
        logic        e_halted;
        logic [31:0] e_imem;
    } vec_t;

    localparam int NV = 24;
    vec_t tv [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic rv, input logic [31:0] rp, input logic rdy);
        rst            = r;
        redirect_valid = rv;
        redirect_pc    = rp;
        id_ready       = rdy;
        @(posedge clk);
        #1;
    endtask

    logic [31:0] exp_pc;
    logic [31:0] last_pc;
    logic        ev0, ev1, ev2;

    initial begin
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; id_ready = 1'b0;

        //           rst   rv    rpc         rdy   val   cpc   pc          cin   inst            hlt   imem_a
        tv[0]  = '{1'b1, 1'b0, 32'h0,      1'b0, 1'b0, 1'b0, 32'h0,      1'b0, 32'h0,          1'b0, 32'h0};
        tv[1]  = '{1'b1, 1'b0, 32'h0,      1'b0, 1'b0, 1'b0, 32'h0,      1'b0, 32'h0,          1'b0, 32'h0};
        tv[2]  = '{1'b0, 1'b0, 32'h0,      1'b0, 1'b1, 1'b1, 32'h0,      1'b1, 32'hFFC1_0113,  1'b0, 32'h4};
        tv[3]  = '{1'b0, 1'b0, 32'h0,      1'b0, 1'b1, 1'b1, 32'h0,      1'b0, 32'h0,          1'b0, 32'h8};
        tv[4]  = '{1'b0, 1'b0, 32'h0,      1'b0, 1'b1, 1'b1, 32'h0,      1'b0, 32'h0,          1'b0, 32'hC};
        tv[5]  = '{1'b0, 1'b0, 32'h0,      1'b0, 1'b1, 1'b1, 32'h0,      1'b0, 32'h0,          1'b0, 32'h10};
        tv[6]  = '{1'b0, 1'b0, 32'h0,      1'b0, 1'b1, 1'b1, 32'h0,      1'b0, 32'h0,          1'b0, 32'h10};
        tv[7]  = '{1'b0, 1'b0, 32'h0,      1'b0, 1'b1, 1'b1, 32'h0,      1'b0, 32'h0,          1'b0, 32'h10};
        tv[8]  = '{1'b0, 1'b0, 32'h0,      1'b0, 1'b1, 1'b1, 32'h0,      1'b0, 32'h0,          1'b0, 32'h10};
        tv[9]  = '{1'b0, 1'b0, 32'h0,      1'b0, 1'b1, 1'b1, 32'h0,      1'b0, 32'h0,          1'b0, 32'h10};
        tv[10] = '{1'b0, 1'b0, 32'h0,      1'b0, 1'b1, 1'b1, 32'h0,      1'b0, 32'h0,          1'b0, 32'h10};
        tv[11] = '{1'b0, 1'b0, 32'h0,      1'b0, 1'b1, 1'b1, 32'h0,      1'b1, 32'hFFC1_0113,  1'b0, 32'h10};
        tv[12] = '{1'b0, 1'b0, 32'h0,      1'b1, 1'b1, 1'b1, 32'h4,      1'b1, 32'h0010_0013,  1'b0, 32'h14};
        tv[13] = '{1'b0, 1'b0, 32'h0,      1'b1, 1'b1, 1'b1, 32'h8,      1'b0, 32'h0,          1'b0, 32'h18};
        tv[14] = '{1'b0, 1'b0, 32'h0,      1'b1, 1'b1, 1'b1, 32'hC,      1'b0, 32'h0,          1'b0, 32'h1C};
        tv[15] = '{1'b0, 1'b0, 32'h0,      1'b1, 1'b1, 1'b1, 32'h10,     1'b1, 32'h0040_0013,  1'b0, 32'h20};
        tv[16] = '{1'b0, 1'b0, 32'h0,      1'b1, 1'b1, 1'b1, 32'h14,     1'b0, 32'h0,          1'b0, 32'h24};
        tv[17] = '{1'b1, 1'b0, 32'h0,      1'b0, 1'b0, 1'b0, 32'h0,      1'b0, 32'h0,          1'b0, 32'h0};
        tv[18] = '{1'b0, 1'b0, 32'h0,      1'b0, 1'b1, 1'b1, 32'h0,      1'b0, 32'h0,          1'b0, 32'h4};
        tv[19] = '{1'b0, 1'b0, 32'h0,      1'b0, 1'b1, 1'b1, 32'h0,      1'b0, 32'h0,          1'b0, 32'h8};
        tv[20] = '{1'b0, 1'b0, 32'h0,      1'b0, 1'b1, 1'b1, 32'h0,      1'b0, 32'h0,          1'b0, 32'hC};
        tv[21] = '{1'b0, 1'b1, 32'h86,     1'b1, 1'b0, 1'b0, 32'h0,      1'b0, 32'h0,          1'b0, 32'h84};
        tv[22] = '{1'b0, 1'b0, 32'h0,      1'b0, 1'b1, 1'b1, 32'h84,     1'b1, 32'h0210_0013,  1'b0, 32'h88};
        tv[23] = '{1'b0, 1'b0, 32'h0,      1'b1, 1'b1, 1'b1, 32'h88,     1'b1, 32'h0220_0013,  1'b0, 32'h8C};

        for (int i = 0; i < NV; i++) begin
            step(tv[i].rst, tv[i].rv, tv[i].rpc, tv[i].rdy);
            check($sformatf("v%0d_valid", i),  {31'd0, id_valid}, {31'd0, tv[i].e_valid});
            check($sformatf("v%0d_halted", i), {31'd0, halted},   {31'd0, tv[i].e_halted});
            check($sformatf("v%0d_imem_a", i), imem_a, tv[i].e_imem);
            if (tv[i].chk_pc)   check($sformatf("v%0d_pc", i), id_pc, tv[i].e_pc);
            if (tv[i].chk_inst) check($sformatf("v%0d_inst", i), id_inst, tv[i].e_inst);
        end

        // Free-running fetch until the terminator at 0xB4 halts the fetcher.
        step(1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b0);
        exp_pc  = 32'h0;
        last_pc = 32'hFFFF_FFFF;
        rst      = 1'b0;
        id_ready = 1'b1;
        for (int c = 0; c < 300 && !halted; c++) begin
            @(posedge clk);
            #1;
            if (id_valid) begin
                check("run_pc", id_pc, exp_pc);
                check("run_inst_nonzero", {31'd0, (id_inst != 32'h0)}, 32'd1);
                exp_pc  = exp_pc + 32'd4;
                last_pc = id_pc;
            end
        end
        check("halt_flag", {31'd0, halted}, 32'd1);
        check("halt_last_pc", last_pc, 32'hB0);
        check("halt_imem_a", imem_a, 32'hB4);
        check("halt_valid", {31'd0, id_valid}, 32'd0);

        // Redirect out of HALT.
        step(1'b0, 1'b1, 32'h0, 1'b1);
        check("unhalt_halted", {31'd0, halted}, 32'd0);
        check("unhalt_valid", {31'd0, id_valid}, 32'd0);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        check("unhalt_valid2", {31'd0, id_valid}, 32'd1);
        check("unhalt_pc", id_pc, 32'h0);

        // Vector predecode flag.
`ifdef IFETCH_VPREDECODE_EN
        ev0 = 1'b1; ev1 = 1'b1; ev2 = 1'b0;
`else
        ev0 = 1'b0; ev1 = 1'b0; ev2 = 1'b0;
`endif
        step(1'b0, 1'b1, 32'h100, 1'b0);
        check("vec_redir_valid", {31'd0, id_valid}, 32'd0);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        check("vec0_pc", id_pc, 32'h100);
        check("vec0_inst", id_inst, 32'h0205_6087);
        check("vec0_isvec", {31'd0, id_is_vec}, {31'd0, ev0});
        step(1'b0, 1'b0, 32'h0, 1'b1);
        check("vec1_pc", id_pc, 32'h104);
        check("vec1_inst", id_inst, 32'h0106_7457);
        check("vec1_isvec", {31'd0, id_is_vec}, {31'd0, ev1});
        step(1'b0, 1'b0, 32'h0, 1'b1);
        check("vec2_pc", id_pc, 32'h108);
        check("vec2_inst", id_inst, 32'h0040_0513);
        check("vec2_isvec", {31'd0, id_is_vec}, {31'd0, ev2});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ifetch_buf.md
# ifetch_buf

Instruction fetch stage with a small prefetch queue, sitting between the combinational instruction ROM and the decode stage of the RV32IMV core. It drives the word address to the ROM, captures each returned instruction with its PC into a FIFO, and presents them to decode over a valid/ready handshake. It supports redirects from branch/jump resolution and stops fetching on the all-zero terminator word.

## Interface
Parameters:
- DEPTH, 4, prefetch FIFO entries; power of two, at least 2.
- RESET_PC, 32'h0000_0000, fetch address after reset.

Ports:
- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- imem_a  out  32  ROM byte address; ROM indexes it with bits [8:2].
- imem_inst  in  32  ROM data; combinational from imem_a in the same cycle.
- redirect_valid  in  1  flush the queue and restart fetch at redirect_pc.
- redirect_pc  in  32  new fetch PC; bits [1:0] ignored (forced 0).
- id_valid  out  1  queue head valid.
- id_ready  in  1  decode accepts the head this cycle.
- id_inst  out  32  head instruction.
- id_pc  out  32  head PC.
- id_is_vec  out  1  head is a vector instruction (see Configuration).
- halted  out  1  fetcher in HALT and queue empty.

## Operation
- State: fpc (32), FSM {RUN, HALT}, FIFO of {pc, inst, is_vec}, rd_ptr/wr_ptr (log2 DEPTH, wrap mod DEPTH), count (log2(DEPTH+1) bits).
- imem_a = fpc at all times.
- pop = id_valid & id_ready. push = RUN & !redirect_valid & imem_inst != 0 & (count < DEPTH | pop).
- On push: the entry {fpc, imem_inst} is written and fpc <= fpc + 4. fpc wraps modulo 2^32.
- If the FIFO is full and pop is high in the same cycle, a push is allowed (simultaneous push and pop). count is then unchanged.
- RUN -> HALT: in RUN, with no redirect and the FIFO able to accept, imem_inst == 32'h0. The zero word is not enqueued, and fpc holds (points at the zero word).
- HALT: no pushes. The queue continues to drain to decode.
- Redirect has the highest priority, from any state. The FIFO is flushed (count, pointers = 0), fpc <= {redirect_pc[31:2], 2'b00}, state <= RUN, and nothing is pushed or popped that cycle.
- id_* outputs reflect the FIFO head, and are meaningful only when id_valid = 1. id_valid = (count != 0).
- halted = (state == HALT) & (count == 0).

## Timing
- Reset (rst=1 at an edge): fpc = RESET_PC, state = RUN, count = 0. Outputs after reset: id_valid = 0, halted = 0, imem_a = RESET_PC. id_inst, id_pc and id_is_vec read the entry at pointer 0; their values are don't-care while id_valid = 0.
- Reset asserted mid-stream discards all queued entries and any redirect in that cycle.
- Fetch-to-decode latency: 1 cycle. A word fetched in cycle N is at the head in cycle N+1 if the queue was empty.
- Throughput: 1 instruction/cycle with id_ready held high.
- Redirect in cycle N: id_valid = 0 in cycle N+1; the target instruction is at the head in cycle N+2.
- Handshake: while id_valid = 1 and id_ready = 0, the id_* outputs are stable.

## Configuration
- IFETCH_VPREDECODE_EN defined: is_vec is computed at push time and stored per entry. It is 1 when imem_inst[6:0] is 1010111 (OP-V), or when it is 0000111 / 0100111 (LOAD-FP / STORE-FP) with imem_inst[14:12] in {000, 101, 110, 111} (vector widths).
- IFETCH_VPREDECODE_EN undefined: no storage for the flag, and id_is_vec is tied to 0.

## Structure
- A shared package holds:
  - OPC_OPV = 7'b1010111, OPC_LOADFP = 7'b0000111, OPC_STOREFP = 7'b0100111;
  - INST_TERM = 32'h0;
  - the fetch FSM state enum.
- One sub-module: ifetch_fifo. It is a generic synchronous FIFO with flush, parameterised on width and depth, and exposes count, full, empty and simultaneous push/pop.

## Test plan
- Reset with rst=1 for 2 cycles -> imem_a = 0x0, id_valid = 0, halted = 0. The first cycle after release gives id_valid = 1, id_pc = 0x0, id_inst = 0xFFC10113.
- id_ready = 1 continuously -> id_pc = 0x0, 0x4, 0x8, 0xC on consecutive cycles, one per cycle, no bubbles.
- id_ready = 0 for 10 cycles after reset -> the queue holds 4 entries and imem_a sticks at 0x10. After release, id_pc = 0x0, 0x4, 0x8, 0xC, 0x10 in order with no loss or duplication.
- Redirect to 0x86 with 3 entries queued -> the next cycle has id_valid = 0. The cycle after has id_pc = 0x84 (bits [1:0] forced to 0) and id_inst = 0x0000_0000 is never presented.
- Free-running fetch of a program whose word at 0xB4 is 0x00000000 -> the last id_pc delivered is 0xB0, then halted = 1. A subsequent redirect to 0x0 clears halted, and id_pc = 0x0 follows.
- With IFETCH_VPREDECODE_EN: id_inst = 0x02056087 (vle32.v) gives id_is_vec = 1; 0x01067457 (vsetvli) gives 1; 0x00400513 (addi) gives 0. Without the macro: id_is_vec = 0 for all three.
